// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, sequencer
// states and the ALU control encodings driven onto the datapath.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LS    = 4'b0010;
  localparam logic [3:0] OP_SS    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWr   = 4'd6,
    StWbR     = 4'd7,
    StWbI     = 4'd8,
    StWbMem   = 4'd9,
    StBranch  = 4'd10,
    StFault   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SrcBReg = 2'b00,
    SrcBOne = 2'b01,
    SrcBImm = 2'b10
  } alu_src_b_e;

  // States that wait on the memory handshake and therefore run the stall timer.
  function automatic logic isMemState(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Consecutive-stall counter; expired flags the cycle on which one more stall
// would exceed WAIT_MAX. WAIT_MAX = 0 never expires.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  logic [CntW-1:0] cntQ;

  assign expired = (WAIT_MAX != 0) && (cntQ == CntW'(WAIT_MAX));

  // Saturates at WAIT_MAX so a held value can never wrap back below the limit.
  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      cntQ <= '0;
    end else if (count && !expired) begin
      cntQ <= cntQ + 1'b1;
    end
  end

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, driving datapath enables and mux selects.
module multi_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] OPCODE,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       InstrDone,
  output logic       Fault,
  output logic [3:0] StateOut
);

  state_e stateQ, stateD;
  logic   waitExpired;
  logic   unusedZero;

  // Zero gates the PC load in the datapath, not here.
  assign unusedZero = Zero;
  assign StateOut   = stateQ;

  mem_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) uWaitTimer (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (stateD != stateQ),
    .count  (isMemState(stateQ) && !MemReady),
    .expired(waitExpired)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ <= StFetch;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD      = stateQ;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = SrcBReg;
    AluOp       = AluAdd;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    InstrDone   = 1'b0;
    Fault       = 1'b0;

    unique case (stateQ)
      StFetch: begin
        MemRead = 1'b1;
        AluSrcB = SrcBOne;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady)         stateD = StDecode;
        else if (waitExpired) stateD = StFault;
      end
      StDecode: begin
        AluSrcB = SrcBImm;
        unique case (OPCODE)
          OP_RTYPE:     stateD = StExecR;
          OP_ADDI:      stateD = StExecI;
          OP_LS, OP_SS: stateD = StMemAddr;
          OP_BEQ:       stateD = StBranch;
          default:      stateD = StFault;
        endcase
      end
      StExecR: begin
        AluSrcA = 1'b1;
        AluOp   = AluFunct;
        stateD  = StWbR;
      end
      StWbR: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        stateD    = StFetch;
      end
      StExecI: begin
        AluSrcA = 1'b1;
        AluSrcB = SrcBImm;
        stateD  = StWbI;
      end
      StWbI: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        stateD    = StFetch;
      end
      StMemAddr: begin
        AluSrcA = 1'b1;
        AluSrcB = SrcBImm;
        stateD  = (OPCODE == OP_SS) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)         stateD = StWbMem;
        else if (waitExpired) stateD = StFault;
      end
      StWbMem: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        InstrDone = 1'b1;
        stateD    = StFetch;
      end
      StMemWr: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        if (MemReady)         stateD = StFetch;
        else if (waitExpired) stateD = StFault;
      end
      StBranch: begin
        AluSrcA     = 1'b1;
        AluOp       = AluSub;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        InstrDone   = 1'b1;
        stateD      = StFetch;
      end
      StFault: begin
        Fault = 1'b1;
      end
      // Unused encodings are treated as a fault rather than silently recovering.
      default: stateD = StFault;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Bench for multi_cycle_sequencer: a per-opcode phase-list model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_multi_cycle_sequencer;
  import cpu_pkg::*;

  localparam int WaitMax = 3;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regDst;
    logic       regWrite;
    logic       memToReg;
    logic       instrDone;
    logic       fault;
  } outs_t;

  logic       Clock, Reset, Zero, MemReady;
  logic [3:0] OPCODE;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, AluSrcA;
  logic [1:0] AluSrcB, AluOp;
  logic       RegDst, RegWrite, MemToReg, InstrDone, Fault;
  logic [3:0] StateOut;
  outs_t      act;

  int checks = 0;
  int errors = 0;

  multi_cycle_sequencer #(
    .WAIT_MAX(WaitMax)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .OPCODE     (OPCODE),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .PCSource   (PCSource),
    .AluSrcA    (AluSrcA),
    .AluSrcB    (AluSrcB),
    .AluOp      (AluOp),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .MemToReg   (MemToReg),
    .InstrDone  (InstrDone),
    .Fault      (Fault),
    .StateOut   (StateOut)
  );

  assign act = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, AluSrcA,
                AluSrcB, AluOp, RegDst, RegWrite, MemToReg, InstrDone, Fault};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- model: each opcode is a fixed list of phases ----------------
  function automatic int seqLen(logic [3:0] op);
    case (op)
      4'b0110, 4'b0001, 4'b0011: return 4;
      4'b0010:                   return 5;
      default:                   return 3;
    endcase
  endfunction

  function automatic state_e phaseAt(logic [3:0] op, int idx);
    if (idx == 0) return StFetch;
    if (idx == 1) return StDecode;
    case (op)
      4'b0110: return (idx == 2) ? StExecR : StWbR;
      4'b0001: return (idx == 2) ? StExecI : StWbI;
      4'b0010: return (idx == 2) ? StMemAddr : (idx == 3) ? StMemRd : StWbMem;
      4'b0011: return (idx == 2) ? StMemAddr : StMemWr;
      4'b0100: return StBranch;
      default: return StFault;
    endcase
  endfunction

  function automatic logic waitsOnMem(state_e ph);
    return (ph == StFetch) || (ph == StMemRd) || (ph == StMemWr);
  endfunction

  function automatic outs_t expOut(state_e ph, logic rdy);
    outs_t o;
    o = '0;
    case (ph)
      StFetch:   begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = rdy; o.pcWrite = rdy; end
      StDecode:  o.aluSrcB = 2'b10;
      StExecR:   begin o.aluSrcA = 1; o.aluOp = 2'b10; end
      StWbR:     begin o.regDst = 1; o.regWrite = 1; o.instrDone = 1; end
      StExecI, StMemAddr: begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
      StWbI:     begin o.regWrite = 1; o.instrDone = 1; end
      StMemRd:   begin o.memRead = 1; o.iorD = 1; end
      StWbMem:   begin o.regWrite = 1; o.memToReg = 1; o.instrDone = 1; end
      StMemWr:   begin o.memWrite = 1; o.iorD = 1; o.instrDone = rdy; end
      StBranch:  begin
        o.aluSrcA = 1; o.aluOp = 2'b01; o.pcWriteCond = 1; o.pcSource = 1; o.instrDone = 1;
      end
      StFault:   o.fault = 1;
      default:   ;
    endcase
    return o;
  endfunction

  logic mValid = 1'b0;
  logic mFault = 1'b0;
  int   mIdx   = 0;
  int   mStall = 0;

  function automatic state_e modelPhase(logic flt, int idx, logic [3:0] op);
    return flt ? StFault : phaseAt(op, idx);
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      mValid <= 1'b1;
      mFault <= 1'b0;
      mIdx   <= 0;
      mStall <= 0;
    end else if (mValid && !mFault) begin
      if (waitsOnMem(modelPhase(mFault, mIdx, OPCODE)) && !MemReady) begin
        // Stall number WaitMax+1 in a row is the one that faults.
        if (WaitMax != 0 && mStall == WaitMax) mFault <= 1'b1;
        else mStall <= mStall + 1;
      end else begin
        mStall <= 0;
        if (mIdx + 1 >= seqLen(OPCODE)) mIdx <= 0;
        else if (phaseAt(OPCODE, mIdx + 1) == StFault) mFault <= 1'b1;
        else mIdx <= mIdx + 1;
      end
    end
  end

  always @(negedge Clock) begin
    if (mValid) begin
      checks++;
      if (act !== expOut(modelPhase(mFault, mIdx, OPCODE), MemReady) ||
          StateOut !== modelPhase(mFault, mIdx, OPCODE)) begin
        errors++;
        $display("FAIL model t=%0t: state got %0d want %0d, outputs got %b want %b", $time,
                 StateOut, modelPhase(mFault, mIdx, OPCODE), act,
                 expOut(modelPhase(mFault, mIdx, OPCODE), MemReady));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] hState [1:32];
  outs_t      hOut   [1:32];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Cycle i of a run uses bit i-1 of rdy/rst; results land in hState/hOut[i].
  task automatic run(input logic [3:0] op, input int n, input logic [31:0] rdy,
                     input logic [31:0] rst);
    for (int i = 1; i <= n; i++) begin
      @(posedge Clock);
      #1;
      Reset    = rst[i-1];
      OPCODE   = op;
      MemReady = rdy[i-1];
      @(negedge Clock);
      hState[i] = StateOut;
      hOut[i]   = act;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic strobes;
    Reset = 1'b1; OPCODE = 4'b0000; MemReady = 1'b0; Zero = 1'b0;
    run(4'b0000, 2, 32'h0, 32'hFFFF_FFFF);

    // R-format, zero-wait memory
    run(4'b0110, 4, 32'hFFFF_FFFF, 32'h0);
    chk("reset state", hState[1], StFetch);
    chk("reset MemRead", hOut[1].memRead, 1);
    chk("reset IorD", hOut[1].iorD, 0);
    chk("reset Fault", hOut[1].fault, 0);
    chk("reset InstrDone", hOut[1].instrDone, 0);
    chk("R cycle2 state", hState[2], StDecode);
    chk("R cycle3 state", hState[3], StExecR);
    chk("R cycle4 state", hState[4], StWbR);
    chk("R cycle3 RegWrite", hOut[3].regWrite, 0);
    chk("R cycle4 RegWrite", hOut[4].regWrite, 1);
    chk("R cycle4 RegDst", hOut[4].regDst, 1);
    chk("R cycle4 InstrDone", hOut[4].instrDone, 1);

    // LS with two wait cycles in MEM_RD
    run(4'b0010, 7, 32'hFFFF_FFE7, 32'h0);
    cnt = 0;
    for (int i = 1; i <= 7; i++) cnt += int'(hOut[i].memRead && hOut[i].iorD);
    chk("LS MemRead+IorD cycles", cnt, 3);
    chk("LS cycle7 state", hState[7], StWbMem);
    chk("LS cycle7 MemToReg", hOut[7].memToReg, 1);
    cnt = 0;
    for (int i = 1; i <= 7; i++) cnt += int'(hOut[i].instrDone);
    chk("LS InstrDone count", cnt, 1);
    chk("LS cycle7 InstrDone", hOut[7].instrDone, 1);

    // BEQ, then ADDI must start from FETCH
    run(4'b0100, 3, 32'hFFFF_FFFF, 32'h0);
    chk("BEQ cycle3 PCWriteCond", hOut[3].pcWriteCond, 1);
    chk("BEQ cycle3 PCSource", hOut[3].pcSource, 1);
    chk("BEQ cycle3 AluOp", hOut[3].aluOp, 1);
    run(4'b0001, 4, 32'hFFFF_FFFF, 32'h0);
    chk("after BEQ state", hState[1], StFetch);
    chk("ADDI cycle3 state", hState[3], StExecI);
    chk("ADDI cycle4 RegWrite", hOut[4].regWrite, 1);
    chk("ADDI cycle4 RegDst", hOut[4].regDst, 0);

    // SS zero wait
    run(4'b0011, 4, 32'hFFFF_FFFF, 32'h0);
    chk("SS cycle4 state", hState[4], StMemWr);
    chk("SS cycle4 MemWrite", hOut[4].memWrite, 1);
    chk("SS cycle4 InstrDone", hOut[4].instrDone, 1);

    // LS: ready arrives on the cycle the stall count hits WaitMax
    run(4'b0010, 8, 32'hFFFF_FFC7, 32'h0);
    chk("LS boundary cycle7 state", hState[7], StMemRd);
    chk("LS boundary cycle8 state", hState[8], StWbMem);
    chk("LS boundary no fault", hOut[8].fault, 0);

    // Illegal opcode, sticky fault, reset recovery
    run(4'b1111, 22, 32'hFFFF_FFFF, 32'h0);
    chk("illegal cycle3 state", hState[3], StFault);
    cnt = 0;
    strobes = 1'b0;
    for (int i = 3; i <= 22; i++) begin
      cnt += int'(hOut[i].fault);
      strobes |= hOut[i].memRead | hOut[i].memWrite | hOut[i].regWrite | hOut[i].irWrite |
                 hOut[i].pcWrite | hOut[i].pcWriteCond;
    end
    chk("illegal Fault sticky cycles", cnt, 20);
    chk("illegal strobes", int'(strobes), 0);
    run(4'b0110, 1, 32'h0, 32'h1);
    run(4'b0110, 1, 32'h0, 32'h0);
    chk("fault reset state", hState[1], StFetch);
    chk("fault reset Fault", hOut[1].fault, 0);

    // FETCH timeout with WaitMax = 3
    run(4'b0110, 4, 32'h0, 32'h0);
    chk("timeout cycle5 state", hState[4], StFault);
    run(4'b0110, 1, 32'h0, 32'h1);
    run(4'b0110, 5, 32'h0000_0008, 32'h0);
    chk("no-timeout cycle4 state", hState[4], StFetch);
    chk("no-timeout cycle5 state", hState[5], StDecode);
    chk("no-timeout Fault", hOut[5].fault, 0);
    run(4'b0110, 2, 32'hFFFF_FFFF, 32'h0);
    chk("no-timeout R done", hOut[2].instrDone, 1);

    // SS with reset during the MEM_WR stall
    run(4'b0011, 6, 32'hFFFF_FFE7, 32'h0000_0010);
    chk("SS stall cycle5 state", hState[5], StMemWr);
    chk("SS stall cycle4 InstrDone", hOut[4].instrDone, 0);
    chk("SS reset cycle6 state", hState[6], StFetch);
    chk("SS reset cycle6 MemWrite", hOut[6].memWrite, 0);

    @(posedge Clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
